hex_digit_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Takes the 16-bit hex value driven by the hex_digits PIO output port (4 nibbles) plus a load strobe.
- Double-buffers the value so updates only take effect at frame boundaries (tear-free).
- Sequences digit anodes with dwell and anti-ghost gap intervals, decodes nibbles to segments, and optionally blanks leading zeros.

---
 rtl/hex_digit_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_hex_digit_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hex_digit_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display: double-buffered
// value, dwell/gap digit sequencing, hex decode and optional leading-zero blanking.
module hex_digit_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 0,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        enable,
  input  logic        lz_blank_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        frame_done,
  output logic        pending
);

  typedef enum logic {SHOW, GAP} state_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q;
  logic [1:0]       digit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q;
  logic             pend_flag_q, pend_flag_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             frame_done_q;

  logic             advance;
  logic             wrap;
  logic [3:0]       nibble;
  logic             blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    advance = 1'b0;
    if (enable) begin
      if (state_q == SHOW)
        advance = (cnt_q == DWELL_LAST) && (GAP_CYCLES == 0);
      else
        advance = (cnt_q == GAP_LAST);
    end
    wrap = advance && (digit_q == 2'd3);

    // A load coinciding with the boundary goes straight to the display.
    disp_d      = disp_q;
    pend_flag_d = pend_flag_q;
    if (wrap) begin
      pend_flag_d = 1'b0;
      if (load)
        disp_d = value_in;
      else if (pend_flag_q)
        disp_d = pend_q;
    end else if (load) begin
      pend_flag_d = 1'b1;
    end

    nibble = disp_q[{digit_q, 2'b00} +: 4];
    case (digit_q)
      2'd1:    blank = (disp_q[15:4]  == 12'h000);
      2'd2:    blank = (disp_q[15:8]  == 8'h00);
      2'd3:    blank = (disp_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    blank = blank && lz_blank_en;

    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    if (enable && (state_q == SHOW) && !blank) begin
      an_n_d  = ~(4'b0001 << digit_q);
      seg_n_d = decode(nibble);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SHOW;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      disp_q       <= 16'h0000;
      pend_flag_q  <= 1'b0;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      disp_q       <= disp_d;
      pend_flag_q  <= pend_flag_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= wrap;
      if (enable) begin
        case (state_q)
          SHOW: begin
            if (cnt_q == DWELL_LAST) begin
              cnt_q <= '0;
              if (GAP_CYCLES > 0)
                state_q <= GAP;
              else
                digit_q <= digit_q + 2'd1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              digit_q <= digit_q + 2'd1;
              state_q <= SHOW;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // NOTE: the pending data register has no reset; it is only ever read while
  // pend_flag_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (load && !wrap)
      pend_q <= value_in;
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pend_flag_q;

endmodule

// File: tb/tb_hex_digit_scan_ctrl.sv
// Directed bench for hex_digit_scan_ctrl with DWELL=4, GAP=2 (24-cycle frames);
// expected digit patterns are hand-derived per frame.
module tb_hex_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic        lz_blank_en = 1'b0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;
  logic exp_pend = 1'b0;

  hex_digit_scan_ctrl #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load), .enable(enable),
    .lz_blank_en(lz_blank_en), .an_n(an_n), .seg_n(seg_n),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a frame_done sample, checks the 24 following samples and ends on the
  // next frame_done. segs = {s3,s2,s1,s0}; lit marks digits not blanked.
  task automatic run_frame(input string name, input logic [27:0] segs, input logic [3:0] lit,
                           input int off_a, input logic [15:0] val_a,
                           input int off_b, input logic [15:0] val_b);
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    logic       ld_was;
    int k, pos;
    for (int i = 1; i <= 24; i++) begin
      tick();
      ld_was = load;
      load = 1'b0;
      if (ld_was && i != 24) exp_pend = 1'b1;
      if (i == 24) exp_pend = 1'b0;
      k   = (i - 1) / 6;
      pos = (i - 1) % 6;
      an_exp  = 4'hF;
      seg_exp = 7'h7F;
      if (pos < 4 && lit[k]) begin
        an_exp  = 4'(~(4'b0001 << k));
        seg_exp = segs[7*k +: 7];
      end
      check($sformatf("%s an_n @%0d", name, i), {12'h0, an_n}, {12'h0, an_exp});
      check($sformatf("%s seg_n @%0d", name, i), {9'h0, seg_n}, {9'h0, seg_exp});
      check($sformatf("%s frame_done @%0d", name, i), {15'h0, frame_done}, {15'h0, (i == 24)});
      check($sformatf("%s pending @%0d", name, i), {15'h0, pending}, {15'h0, exp_pend});
      if (i == off_a) begin load = 1'b1; value_in = val_a; end
      if (i == off_b) begin load = 1'b1; value_in = val_b; end
    end
  endtask

  initial begin
    int n;
    // Reset state
    tick(); tick(); tick();
    check("reset an_n", {12'h0, an_n}, 16'h000F);
    check("reset seg_n", {9'h0, seg_n}, 16'h007F);
    check("reset frame_done", {15'h0, frame_done}, 16'h0000);
    check("reset pending", {15'h0, pending}, 16'h0000);

    // Test 1: load 0x1A3F in the first cycle, wait for the boundary
    reset = 1'b0; load = 1'b1; value_in = 16'h1A3F;
    tick();
    load = 1'b0;
    check("t1 pending after load", {15'h0, pending}, 16'h0001);
    n = 1;
    while (!frame_done && n < 40) begin tick(); n++; end
    check("t1 first frame_done latency", 16'(n), 16'd24);
    check("t1 pending at boundary", {15'h0, pending}, 16'h0000);
    exp_pend = 1'b0;
    run_frame("t1", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'hF, -1, 16'h0, -1, 16'h0);

    // Test 2: load 0x1234 at cycle 5; old value stays up until the boundary
    run_frame("t2a", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'hF, 5, 16'h1234, -1, 16'h0);
    // Test 3: two loads in one frame, last one wins
    run_frame("t2b", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 3, 16'h1111, 15, 16'h2222);
    // Test 4: 0x5555 pending, 0x00C0 loaded in the exact boundary cycle
    run_frame("t3", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 8, 16'h5555, 23, 16'h00C0);
    run_frame("t4", {7'h40, 7'h40, 7'h46, 7'h40}, 4'hF, -1, 16'h0, -1, 16'h0);

    // Test 5: leading-zero blanking
    lz_blank_en = 1'b1;
    run_frame("t5a", {7'h40, 7'h40, 7'h46, 7'h40}, 4'h3, 10, 16'h0040, -1, 16'h0);
    run_frame("t5b", {7'h40, 7'h40, 7'h19, 7'h40}, 4'h3, 4, 16'h0000, -1, 16'h0);
    run_frame("t5c", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h1, -1, 16'h0, -1, 16'h0);

    // Test 6: reset mid-digit-2 discards a pending value
    lz_blank_en = 1'b0;
    load = 1'b1; value_in = 16'hBEEF;
    tick();
    load = 1'b0;
    check("t6 pending before reset", {15'h0, pending}, 16'h0001);
    for (int i = 2; i <= 14; i++) tick();
    check("t6 digit2 lit before reset", {12'h0, an_n}, 16'h000B);
    reset = 1'b1;
    tick();
    check("t6 reset an_n", {12'h0, an_n}, 16'h000F);
    check("t6 reset seg_n", {9'h0, seg_n}, 16'h007F);
    check("t6 reset pending", {15'h0, pending}, 16'h0000);
    reset = 1'b0;
    tick();
    check("t6 digit0 an_n", {12'h0, an_n}, 16'h000E);
    check("t6 digit0 seg_n", {9'h0, seg_n}, 16'h0040);
    tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t6 disabled an_n %0d", i), {12'h0, an_n}, 16'h000F);
      check($sformatf("t6 disabled seg_n %0d", i), {9'h0, seg_n}, 16'h007F);
      check($sformatf("t6 disabled frame_done %0d", i), {15'h0, frame_done}, 16'h0000);
    end
    enable = 1'b1;
    tick();
    check("t6 resume an_n", {12'h0, an_n}, 16'h000E);
    check("t6 resume seg_n", {9'h0, seg_n}, 16'h0040);
    n = 13;
    while (!frame_done && n < 60) begin tick(); n++; end
    check("t6 stretched frame_done latency", 16'(n), 16'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
